// File: rtl/telemetry_tx.sv
// telemetry_tx
//   Periodically snapshots battery voltage, motor current and pedal torque,
//   frames them into an 8-byte packet (AA 55 then three 12-bit values split
//   into high nibble / low byte) and sends it as back-to-back 8N1 UART frames.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   batt       : conditioned battery voltage (12 bit)
//   avg_curr   : averaged motor current (12 bit)
//   avg_torque : averaged pedal torque (12 bit)
//   TX         : UART serial output, idles high (registered)
//   busy       : high while a packet is on the line (registered)
//   pkt_done   : one-cycle pulse after the last stop bit of a packet
module telemetry_tx #(
  parameter int BAUD_DIV   = 2604,
  parameter int PKT_PERIOD = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] avg_curr,
  input  logic [11:0] avg_torque,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);

  localparam int PW = (PKT_PERIOD > 1) ? $clog2(PKT_PERIOD) : 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [PW-1:0] PER_LAST  = PW'(PKT_PERIOD - 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XMIT = 1'b1;

  logic [PW-1:0] per_cnt_q,  per_cnt_d;
  logic [0:0]    state_q,    state_d;
  logic [11:0]   batt_q,     batt_d;
  logic [11:0]   curr_q,     curr_d;
  logic [11:0]   torque_q,   torque_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q,  bit_cnt_d;
  logic [9:0]    shift_q,    shift_d;
  logic          tx_q,       tx_d;
  logic          busy_q,     busy_d;
  logic          pkt_done_q, pkt_done_d;
  logic          tick;

  function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                          input logic [11:0] b,
                                          input logic [11:0] c,
                                          input logic [11:0] t);
    logic [7:0] r;
    case (idx)
      3'd0:    r = 8'hAA;
      3'd1:    r = 8'h55;
      3'd2:    r = {4'h0, b[11:8]};
      3'd3:    r = b[7:0];
      3'd4:    r = {4'h0, c[11:8]};
      3'd5:    r = c[7:0];
      3'd6:    r = {4'h0, t[11:8]};
      default: r = t[7:0];
    endcase
    return r;
  endfunction

  // 8N1 frame, shifted out from bit 0: start(0), data LSB first, stop(1).
  function automatic logic [9:0] frame(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  always_comb begin
    tick       = (per_cnt_q == PER_LAST);
    per_cnt_d  = tick ? '0 : per_cnt_q + PW'(1);
    state_d    = state_q;
    batt_d     = batt_q;
    curr_d     = curr_q;
    torque_d   = torque_q;
    byte_idx_d = byte_idx_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    pkt_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tick) begin
          // Snapshot and first start bit land on the same edge, so byte 0
          // goes out without an idle bit in front of it.
          state_d    = XMIT;
          busy_d     = 1'b1;
          batt_d     = batt;
          curr_d     = avg_curr;
          torque_d   = avg_torque;
          byte_idx_d = '0;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          shift_d    = frame(pkt_byte(3'd0, batt, avg_curr, avg_torque));
          tx_d       = 1'b0;
        end
      end
      default: begin
        // Ticks are ignored here: the period counter keeps running.
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = '0;
            if (byte_idx_q == 3'd7) begin
              state_d    = IDLE;
              busy_d     = 1'b0;
              tx_d       = 1'b1;
              pkt_done_d = 1'b1;
              byte_idx_d = '0;
            end else begin
              // Next start bit follows the stop bit directly.
              byte_idx_d = byte_idx_q + 3'd1;
              shift_d    = frame(pkt_byte(byte_idx_q + 3'd1, batt_q, curr_q, torque_q));
              tx_d       = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {1'b1, shift_q[9:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q  <= '0;
      state_q    <= IDLE;
      batt_q     <= '0;
      curr_q     <= '0;
      torque_q   <= '0;
      byte_idx_q <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      per_cnt_q  <= per_cnt_d;
      state_q    <= state_d;
      batt_q     <= batt_d;
      curr_q     <= curr_d;
      torque_q   <= torque_d;
      byte_idx_q <= byte_idx_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;

endmodule
